// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver:
// display codes, active-low segment patterns, converter FSM states.
package ssd_pkg;

    // Display code: 5'h00..5'h0F are hex digits, bit 4 marks the special glyphs.
    typedef logic [4:0] code_t;

    localparam code_t CODE_BLANK = {1'b1, 4'h0};
    localparam code_t CODE_DASH  = {1'b1, 4'h1};

    // Active-low segments, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // 10**n, evaluated at elaboration to size the decimal overflow limit.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [6:0] seg_decode(input code_t code);
        logic [6:0] seg;
        case (code)
            5'h00:     seg = SEG_0;
            5'h01:     seg = SEG_1;
            5'h02:     seg = SEG_2;
            5'h03:     seg = SEG_3;
            5'h04:     seg = SEG_4;
            5'h05:     seg = SEG_5;
            5'h06:     seg = SEG_6;
            5'h07:     seg = SEG_7;
            5'h08:     seg = SEG_8;
            5'h09:     seg = SEG_9;
            5'h0A:     seg = SEG_A;
            5'h0B:     seg = SEG_B;
            5'h0C:     seg = SEG_C;
            5'h0D:     seg = SEG_D;
            5'h0E:     seg = SEG_E;
            5'h0F:     seg = SEG_F;
            CODE_DASH: seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Load/busy bus between the debug-display source and the scan driver.
interface ssd_scan_driver_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] value;
    logic              mode;
    logic              load;
    logic              busy;

    modport master (output value, mode, load, input busy);
    modport slave  (input value, mode, load, output busy);
endinterface

// File: rtl/ssd_scan_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock.
// done pulses for one cycle while the finished digits sit on bcd/ovf.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);
    localparam logic [63:0]      LIMIT     = pow10(DIGITS);

    state_t              state, state_next;
    logic [DATA_W-1:0]   shreg;
    logic [4*DIGITS-1:0] bcd_q, bcd_next;
    logic [CNT_W-1:0]    step;
    logic                ovf_q;
    logic [3:0]          nib;
    logic                carry;

    // State register.
    // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state: IDLE -> SHIFT on start, DATA_W steps, one COMMIT cycle.
    // NOTE: the default on the first line keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (step == LAST_STEP) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift left with the next binary bit.
    always_comb begin
        bcd_next = '0;
        nib      = '0;
        carry    = shreg[DATA_W-1];
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd_q[4*i +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            bcd_next[4*i +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
    end

    // Conversion datapath: latch operand and overflow on start, iterate while shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            bcd_q <= '0;
            step  <= '0;
            ovf_q <= 1'b0;
        end else if (state == IDLE && start) begin
            shreg <= bin;
            bcd_q <= '0;
            step  <= '0;
            ovf_q <= (64'(bin) >= LIMIT);
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            bcd_q <= bcd_next;
            step  <= step + 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == COMMIT);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver for the debug display: latches a
// value as hex (immediately) or decimal (via bin2bcd_seq), then scans the
// digits with a registered, active-low anode/segment output.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    ssd_scan_driver_if.slave   bus,
    output logic [DIGITS-1:0]  Anode,
    output logic [6:0]         LED_out
);

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int               REF_W    = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    code_t               buffer    [DIGITS];
    code_t               dec_codes [DIGITS];
    logic [IDX_W-1:0]    index;
    logic [REF_W-1:0]    refresh;
    logic [4*DIGITS-1:0] value_hex;
    logic [4*DIGITS-1:0] conv_bcd;
    logic                conv_busy, conv_done, conv_ovf;
    logic                hex_load, dec_start;
    logic                nz_seen;

    // Loads are only honoured while the converter is idle; anything else is dropped.
    assign value_hex = (4*DIGITS)'(bus.value);
    assign hex_load  = bus.load && !conv_busy && !bus.mode;
    assign dec_start = bus.load && !conv_busy &&  bus.mode;
    assign bus.busy  = conv_busy;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (dec_start),
        .bin   (bus.value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Converter result to display codes: dashes on overflow, zeros above the top nonzero digit blanked.
    always_comb begin
        nz_seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dec_codes[i] = {1'b0, conv_bcd[4*i +: 4]};
            if (conv_ovf)
                dec_codes[i] = CODE_DASH;
            else if (BLANK_LZ && i != 0 && !nz_seen && conv_bcd[4*i +: 4] == 4'd0)
                dec_codes[i] = CODE_BLANK;
            if (conv_bcd[4*i +: 4] != 4'd0) nz_seen = 1'b1;
        end
    end

    // Display buffer: whole-buffer writes only, so a partial BCD result never shows.
    // NOTE: the buffer is a few flops rather than a RAM, so it is cleared by the async reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++) buffer[i] <= '0;
        end else if (conv_done) begin
            for (int i = 0; i < DIGITS; i++) buffer[i] <= dec_codes[i];
        end else if (hex_load) begin
            for (int i = 0; i < DIGITS; i++) buffer[i] <= {1'b0, value_hex[4*i +: 4]};
        end
    end

    // Refresh timer and digit index: each digit stays selected for REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh <= '0;
            index   <= '0;
        end else if (refresh == REF_LAST) begin
            refresh <= '0;
            index   <= (index == IDX_LAST) ? '0 : index + 1'b1;
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    // Registered pin drive: anode and segments switch together, one cycle after index/buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Anode   <= '1;
            LED_out <= SEG_BLANK;
        end else begin
            Anode   <= ~(DIGITS'(1) << index);
            LED_out <= seg_decode(buffer[index]);
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboarded bench for ssd_scan_driver: stimulus pushes expected frames and
// busy-pulse lengths; independent monitors watch the pins and compare.
module tb_ssd_scan_driver;

    localparam int DIGITS      = 4;
    localparam int DATA_W      = 16;
    localparam int REFRESH_DIV = 4;
    localparam logic [DIGITS-1:0] A0 = 4'b1110;

    typedef logic [DIGITS-1:0][6:0] frame_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DIGITS-1:0] Anode;
    logic [6:0]        LED_out;

    ssd_scan_driver_if #(.DATA_W(DATA_W)) bus ();

    ssd_scan_driver #(
        .DIGITS      (DIGITS),
        .DATA_W      (DATA_W),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .Anode   (Anode),
        .LED_out (LED_out)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    frame_t frame_q[$];
    int     busy_q[$];
    bit     abort_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Segment table: 0..15 hex glyphs, 16 blank, 17 dash.
    function automatic logic [6:0] seg_of(input int code);
        case (code)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
            17: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    // What the display should show after a load, from plain arithmetic.
    function automatic frame_t model(input bit dec, input int unsigned v);
        frame_t      f;
        bit          lead;
        int unsigned dig;
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (!dec) begin
                f[d] = seg_of(int'((v >> (4*d)) & 32'hF));
            end else if (v >= 10000) begin
                f[d] = seg_of(17);
            end else begin
                dig = (v / (10 ** d)) % 10;
                if (lead && dig == 0 && d != 0) f[d] = seg_of(16);
                else                            f[d] = seg_of(int'(dig));
                if (dig != 0) lead = 1'b0;
            end
        end
        return f;
    endfunction

    // Frame monitor: from the start of a digit-0 window, check each digit's anode, segments and dwell.
    initial begin : frame_mon
        logic [DIGITS-1:0] prev_an;
        logic [DIGITS-1:0] cur;
        logic [DIGITS-1:0] exp_an;
        frame_t            exp_f;
        int                dwell;
        bit                seg_ok;
        prev_an = '1;
        forever begin
            @(negedge clk);
            if (frame_q.size() != 0 && rst === 1'b1 && prev_an != A0 && Anode == A0) begin
                exp_f = frame_q[0];
                for (int d = 0; d < DIGITS; d++) begin
                    cur    = Anode;
                    exp_an = ~(DIGITS'(1) << d);
                    check($sformatf("anode_d%0d", d), cur, exp_an);
                    check($sformatf("seg_d%0d", d), LED_out, exp_f[d]);
                    seg_ok = 1'b1;
                    dwell  = 0;
                    while (Anode == cur && dwell < 4*REFRESH_DIV) begin
                        if (LED_out !== exp_f[d]) seg_ok = 1'b0;
                        dwell++;
                        @(negedge clk);
                    end
                    check($sformatf("dwell_d%0d", d), dwell, REFRESH_DIV);
                    check($sformatf("seg_hold_d%0d", d), seg_ok, 1);
                end
                if (frame_q.size() != 0) void'(frame_q.pop_front());
            end
            prev_an = Anode;
        end
    end

    // Busy monitor: each busy pulse is matched against the expected length.
    initial begin : busy_mon
        int len;
        int exp_len;
        len = 0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                len++;
            end else if (len > 0) begin
                if (busy_q.size() == 0) begin
                    check("busy_unexpected", len, 0);
                end else begin
                    exp_len = busy_q.pop_front();
                    if (abort_pulse) abort_pulse = 1'b0;
                    else             check("busy_len", len, exp_len);
                end
                len = 0;
            end
        end
    end

    task automatic do_load(input bit m, input logic [15:0] v);
        @(posedge clk); #1;
        bus.value = v;
        bus.mode  = m;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 4*DATA_W) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) check("busy_stuck", bus.busy, 0);
    endtask

    task automatic wait_frames_done();
        int n;
        n = 0;
        while (frame_q.size() != 0 && n < 40*DIGITS*REFRESH_DIV) begin
            @(negedge clk);
            n++;
        end
        if (frame_q.size() != 0) begin
            check("frame_timeout", frame_q.size(), 0);
            frame_q.delete();
        end
    endtask

    task automatic transact(input bit m, input logic [15:0] v);
        if (m) busy_q.push_back(DATA_W + 1);
        do_load(m, v);
        check(m ? "dec_busy" : "hex_busy", bus.busy, m);
        wait_idle();
        repeat (2) @(posedge clk);
        frame_q.push_back(model(m, v));
        wait_frames_done();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit          m;
        int unsigned v;
        bus.value = '0;
        bus.mode  = 1'b0;
        bus.load  = 1'b0;

        // Reset state, then the first edge lights digit 0 showing "0".
        repeat (3) @(posedge clk); #1;
        check("rst_anode", Anode, 4'b1111);
        check("rst_seg", LED_out, 7'b1111111);
        check("rst_busy", bus.busy, 0);
        frame_q.push_back(model(1'b0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("first_anode", Anode, 4'b1110);
        check("first_seg", LED_out, 7'b0000001);
        wait_frames_done();

        // Directed cases.
        transact(1'b0, 16'hA3F0);
        transact(1'b1, 16'd42);
        transact(1'b1, 16'd12345);

        // Load during conversion is dropped.
        busy_q.push_back(DATA_W + 1);
        do_load(1'b1, 16'd9999);
        repeat (3) @(posedge clk); #1;
        bus.value = 16'd1;
        bus.mode  = 1'b1;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        check("busy_hold", bus.busy, 1);
        wait_idle();
        repeat (2) @(posedge clk);
        frame_q.push_back(model(1'b1, 9999));
        wait_frames_done();

        // Reset in the middle of a conversion.
        busy_q.push_back(DATA_W + 1);
        do_load(1'b1, 16'd500);
        repeat (4) @(posedge clk); #1;
        abort_pulse = 1'b1;
        rst = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_anode", Anode, 4'b1111);
        check("abort_seg", LED_out, 7'b1111111);
        frame_q.push_back(model(1'b0, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_frames_done();

        // Boundaries.
        transact(1'b1, 16'd0);
        transact(1'b1, 16'd10000);
        transact(1'b1, 16'd1000);
        transact(1'b0, 16'hFFFF);
        transact(1'b0, 16'h0000);

        // Randomized loads.
        for (int i = 0; i < 12; i++) begin
            m = 1'($urandom_range(0, 1));
            v = m ? $urandom_range(0, 10999) : $urandom_range(0, 65535);
            transact(m, 16'(v));
        end

        repeat (4) @(negedge clk);
        if (busy_q.size() != 0) check("busy_q_drain", busy_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
